// File: rtl/heap_array_reader.sv
// heap_array_reader: streams every element of one heap array out over a valid/ready handshake
module heap_array_reader #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea = 7,
  parameter int NArrays = 4,
  parameter int NHeap = 28
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [MemoryElementWidth-1:0] req_array,
  output logic [MemoryElementWidth-1:0] size_addr,
  input  logic [MemoryElementWidth-1:0] size_data,
  output logic                          heap_rd,
  output logic [MemoryElementWidth-1:0] heap_addr,
  input  logic [MemoryElementWidth-1:0] heap_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MemoryElementWidth-1:0] out_data,
  output logic [MemoryElementWidth-1:0] out_index,
  output logic                          out_last,
  output logic                          done,
  output logic                          error
);
  localparam int W = MemoryElementWidth;
  localparam logic [W-1:0] AREA = W'(NArea);
  localparam logic [W-1:0] NARR = W'(NArrays);
  localparam logic [W-1:0] HEAP = W'(NHeap);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUT} state_t;
  state_t state, state_n;
  logic [W-1:0] arr, size, k;
  logic done_r, error_r, bad, accept;
  // the heap-bound term only matters if the parameters are ever set inconsistently
  assign bad = req_array >= NARR || size_data > AREA || req_array * AREA + size_data > HEAP;
  assign accept = state == IDLE && req_valid;
  always_comb begin
    state_n = state;
    req_ready = 1'b0;
    heap_rd = 1'b0;
    heap_addr = '0;
    out_valid = 1'b0;
    done = done_r;
    error = error_r;
    size_addr = req_array;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        state_n = (req_valid && !bad && size_data != '0) ? ISSUE : IDLE;
      end
      ISSUE: begin
        heap_rd = 1'b1;
        heap_addr = arr * AREA + k;
        state_n = CAPTURE;
      end
      CAPTURE: state_n = OUT;
      OUT: begin
        out_valid = 1'b1;
        done = out_ready && out_last;
        state_n = out_ready ? (out_last ? IDLE : ISSUE) : OUT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      arr <= '0;
      size <= '0;
      k <= '0;
      out_data <= '0;
      out_index <= '0;
      out_last <= 1'b0;
      done_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state <= state_n;
      done_r <= accept && !bad && size_data == '0;
      error_r <= accept && bad;
      if (accept) begin
        arr <= req_array;
        size <= size_data;
        k <= '0;
      end
      if (state == CAPTURE) begin
        out_data <= heap_data;
        out_index <= k;
        out_last <= k == size - W'(1);
      end
      if (state == OUT && out_ready && !out_last) k <= k + W'(1);
    end
  end
endmodule
